// File: rtl/simmem_pkg.sv
// rtl/simmem_pkg.sv - shared sizes and slot state encoding for the simulated memory write-response path
package simmem_pkg;

    localparam int unsigned WRspBankCapa  = 32;
    localparam int unsigned WRspBankAddrW = $clog2(WRspBankCapa);
    localparam int unsigned WRspDelayW    = 6;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_ARMED,
        SLOT_EXPIRED
    } delay_slot_state_e;

endpackage

// File: rtl/simmem_delay_slot.sv
// rtl/simmem_delay_slot.sv - one latency countdown slot: FREE -> ARMED -> EXPIRED -> FREE
module simmem_delay_slot
    import simmem_pkg::*;
#(
    parameter int unsigned DelayW = WRspDelayW
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DelayW-1:0] i_delay,
    input  logic              i_release,
    output delay_slot_state_e o_state,
    output logic              o_expired
);

    delay_slot_state_e r_state;
    logic [DelayW-1:0] r_cnt;

    // i_load is only raised by the parent while the slot is FREE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SLOT_FREE;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_state <= (i_delay != '0) ? SLOT_ARMED : SLOT_EXPIRED;
            r_cnt   <= i_delay;
        end else begin
            case (r_state)
                SLOT_ARMED: begin
                    r_cnt <= r_cnt - DelayW'(1);
                    if (r_cnt == DelayW'(1)) begin
                        r_state <= SLOT_EXPIRED;
                    end
                end
                SLOT_EXPIRED: begin
                    if (i_release) begin
                        r_state <= SLOT_FREE;
                    end
                end
                SLOT_FREE: begin
                    r_state <= SLOT_FREE;
                end
                default: begin
                    r_state <= SLOT_FREE;
                end
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_expired = (r_state == SLOT_EXPIRED);

endmodule

// File: rtl/simmem_wrsp_delay_tracker.sv
// rtl/simmem_wrsp_delay_tracker.sv - per-iid delay tracker driving the write-response bank release enables
module simmem_wrsp_delay_tracker
    import simmem_pkg::*;
#(
    parameter  int unsigned NumSlots = WRspBankCapa,
    parameter  int unsigned DelayW   = WRspDelayW,
    localparam int unsigned AddrW    = $clog2(NumSlots)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [AddrW-1:0]    entry_iid_i,
    input  logic [DelayW-1:0]   entry_delay_i,
    input  logic                entry_valid_i,
    output logic                entry_ready_o,
    output logic [NumSlots-1:0] release_en_o,
    input  logic [NumSlots-1:0] released_addr_onehot_i,
    output logic [AddrW:0]      occupancy_o,
    output logic                empty_o,
    output logic                err_o
);

    delay_slot_state_e w_state [NumSlots];
    logic [NumSlots-1:0] w_expired;
    logic [NumSlots-1:0] w_load;
    logic [NumSlots-1:0] w_release;
    logic                w_ready;
    logic                w_accept;
    logic                w_rel_any;
    logic                w_rel_multi;
    logic                w_rel_bad;
    logic                w_rel_ok;
    logic [AddrW:0]      r_occ;
    logic                r_err;

    assign w_ready  = (w_state[entry_iid_i] == SLOT_FREE);
    assign w_accept = entry_valid_i & w_ready;
    assign w_load   = w_accept ? (NumSlots'(1) << entry_iid_i) : '0;

    // A release is honoured only if it is one-hot and names an EXPIRED slot
    assign w_rel_any   = |released_addr_onehot_i;
    assign w_rel_multi = |(released_addr_onehot_i & (released_addr_onehot_i - NumSlots'(1)));
    assign w_rel_bad   = |(released_addr_onehot_i & ~w_expired);
    assign w_rel_ok    = w_rel_any & ~w_rel_multi & ~w_rel_bad;
    assign w_release   = w_rel_ok ? released_addr_onehot_i : '0;

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        simmem_delay_slot #(
            .DelayW (DelayW)
        ) u_slot (
            .i_clk     (clk_i),
            .i_rst_n   (rst_ni),
            .i_load    (w_load[g]),
            .i_delay   (entry_delay_i),
            .i_release (w_release[g]),
            .o_state   (w_state[g]),
            .o_expired (w_expired[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_occ <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_rel_any && !w_rel_ok) begin
                r_err <= 1'b1;
            end
            case ({w_accept, w_rel_ok})
                2'b10:   r_occ <= r_occ + (AddrW+1)'(1);
                2'b01:   r_occ <= r_occ - (AddrW+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign entry_ready_o = w_ready;
    assign release_en_o  = w_expired;
    assign occupancy_o   = r_occ;
    assign empty_o       = (r_occ == '0);
    assign err_o         = r_err;

endmodule

// File: tb/tb_simmem_wrsp_delay_tracker.sv
// tb/tb_simmem_wrsp_delay_tracker.sv - randomized and directed bench against a deadline-based slot model
module tb_simmem_wrsp_delay_tracker;

    localparam int NS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  entry_iid = '0;
    logic [5:0]  entry_delay = '0;
    logic        entry_valid = 1'b0;
    logic        entry_ready;
    logic [31:0] release_en;
    logic [31:0] released = '0;
    logic [5:0]  occupancy;
    logic        empty;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    // model: a busy slot is expired once the completed edge count reaches its deadline
    bit m_busy [NS];
    int m_deadline [NS];
    int m_occ;
    bit m_err;
    int m_n;

    simmem_wrsp_delay_tracker dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .entry_iid_i            (entry_iid),
        .entry_delay_i          (entry_delay),
        .entry_valid_i          (entry_valid),
        .entry_ready_o          (entry_ready),
        .release_en_o           (release_en),
        .released_addr_onehot_i (released),
        .occupancy_o            (occupancy),
        .empty_o                (empty),
        .err_o                  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_expired(input int i);
        return m_busy[i] && (m_n >= m_deadline[i]);
    endfunction

    function automatic logic [31:0] m_rel_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = m_expired(i);
        return v;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NS; i++) begin
            m_busy[i] = 1'b0;
            m_deadline[i] = 0;
        end
        m_occ = 0;
        m_err = 1'b0;
    endtask

    task automatic cycle(input bit v, input int iid, input int d, input logic [31:0] rel);
        bit acc;
        bit bad;
        int idx;
        @(negedge clk);
        chk("release_en", release_en, m_rel_vec());
        chk("occupancy", occupancy, m_occ);
        chk("empty", empty, m_occ == 0);
        chk("err", err, m_err);
        entry_valid = v;
        entry_iid   = 5'(iid);
        entry_delay = 6'(d);
        released    = rel;
        #1;
        chk("entry_ready", entry_ready, !m_busy[iid]);
        acc = v && !m_busy[iid];
        if (rel != '0) begin
            bad = ($countones(rel) > 1);
            idx = 0;
            for (int i = 0; i < NS; i++) begin
                if (rel[i]) begin
                    idx = i;
                    if (!m_expired(i)) bad = 1'b1;
                end
            end
            if (bad) m_err = 1'b1;
            else begin
                m_busy[idx] = 1'b0;
                m_occ--;
            end
        end
        if (acc) begin
            m_busy[iid] = 1'b1;
            m_deadline[iid] = m_n + 1 + d;
            m_occ++;
        end
        @(posedge clk);
        m_n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        entry_valid = 1'b0;
        released = '0;
        entry_iid = 5'd9;
        #1;
        chk("rst_release_en", release_en, 32'h0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_err", err, 0);
        chk("rst_ready", entry_ready, 1);
        m_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] one;
        int cand[$];
        int guard;
        one = 32'h1;
        m_clear();
        m_n = 0;
        #3;
        chk("init_release_en", release_en, 32'h0);
        chk("init_empty", empty, 1);
        chk("init_ready", entry_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: iid 3, D=5 rises in the 6th cycle after the accept cycle
        do_reset();
        cycle(1, 3, 5, '0);
        for (int k = 0; k <= 6; k++) begin
            #2;
            chk("t1_bit3", release_en[3], k >= 5);
            chk("t1_others", release_en & ~(one << 3), 32'h0);
            cycle(0, 0, 0, '0);
        end

        // 2: D=0 expires immediately, release empties the tracker
        do_reset();
        cycle(1, 0, 0, '0);
        #2;
        chk("t2_bit0", release_en[0], 1);
        chk("t2_occ1", occupancy, 1);
        cycle(0, 0, 0, one);
        #2;
        chk("t2_bit0_clr", release_en[0], 0);
        chk("t2_occ0", occupancy, 0);
        chk("t2_empty", empty, 1);

        // 3: fill, then hold iid 7 until its release is seen
        do_reset();
        for (int i = 0; i < NS; i++) cycle(1, i, 10, '0);
        #2;
        chk("t3_full", occupancy, 32);
        guard = 0;
        while (!m_expired(7) && guard < 20) begin
            cycle(1, 7, 4, '0);
            guard++;
        end
        chk("t3_expired_in_time", m_expired(7), 1);
        cycle(1, 7, 4, one << 7);
        #2;
        chk("t3_occ_after_rel", occupancy, 31);
        cycle(1, 7, 4, '0);
        #2;
        chk("t3_reaccept", occupancy, 32);

        // 4: same-cycle accept of 2 and release of 9
        idle(11);
        cycle(0, 0, 0, one << 2);
        cycle(1, 2, 7, one << 9);
        #2;
        chk("t4_occ", occupancy, 31);
        chk("t4_bit9", release_en[9], 0);
        chk("t4_bit2", release_en[2], 0);
        idle(9);

        // random legal traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [31:0] rel;
            int d;
            rel = '0;
            cand.delete();
            for (int i = 0; i < NS; i++) if (m_expired(i)) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(2, 0) != 0)
                rel = one << cand[$urandom_range(cand.size() - 1, 0)];
            d = ($urandom_range(7, 0) == 0) ? int'($urandom_range(63, 0)) : int'($urandom_range(12, 0));
            cycle($urandom_range(1, 0) == 1, $urandom_range(NS - 1, 0), d, rel);
        end
        idle(70);

        // 5: protocol errors are sticky and ignored
        do_reset();
        cycle(1, 4, 6, '0);
        cycle(0, 0, 0, one << 4);
        #2;
        chk("t5_err", err, 1);
        cycle(0, 0, 0, 32'h3);
        idle(8);
        #2;
        chk("t5_bit4", release_en[4], 1);
        chk("t5_err_sticky", err, 1);

        // 6: reset with armed slots, no stale release afterwards
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 10 + i, 40, '0);
        do_reset();
        idle(50);
        #2;
        chk("t6_no_release", release_en, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
